md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler for the 5-stage pipeline; sits beside the EX-stage ALU.
- Accepts MDU operations from EX, holds them for a fixed latency, then commits the results to the HI/LO registers it owns.
- Raises a stall request to the hazard controller while an ID-stage instruction needs the MDU or HI/LO during an operation.

---
 rtl/md_sched.sv | 94 +++++++++
 tb/tb_md_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multi-cycle MDU scheduler owning HI/LO; commits after MUL_CYCLES/DIV_CYCLES.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu (ops 7-10).
module md_sched #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_start,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        id_md_use,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        start_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);
  state_t      state;
  logic [3:0]  cnt, op_q;
  logic [31:0] a_q, b_q;
  logic        is_mul, is_div, is_long;
  logic        sgn, dz, ovf;
  logic [31:0] dvs, sq, sr, uq, ur;
  logic [63:0] a_x, b_x, prod, div_res, res;
  always_comb begin
    is_div  = ex_op == 4'd3 || ex_op == 4'd4;
`ifdef MDU_MADD_EN
    is_mul  = ex_op == 4'd1 || ex_op == 4'd2 || (ex_op >= 4'd7 && ex_op <= 4'd10);
`else
    is_mul  = ex_op == 4'd1 || ex_op == 4'd2;
`endif
    is_long = is_mul || is_div;
  end
  assign busy      = state == BUSY;
  assign stall_req = id_md_use & (busy | (ex_start & is_long));
  // One 64-bit multiplier serves both signednesses via sign/zero extension.
  always_comb begin
    sgn     = op_q == 4'd1 || op_q == 4'd3 || op_q == 4'd7 || op_q == 4'd9;
    a_x     = {{32{sgn & a_q[31]}}, a_q};
    b_x     = {{32{sgn & b_q[31]}}, b_q};
    prod    = a_x * b_x;
    dz      = b_q == 32'd0;
    ovf     = sgn && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF;
    dvs     = (dz || ovf) ? 32'd1 : b_q;
    sq      = $signed(a_q) / $signed(dvs);
    sr      = $signed(a_q) % $signed(dvs);
    uq      = a_q / dvs;
    ur      = a_q % dvs;
    div_res = dz ? {a_q, 32'hFFFF_FFFF} : sgn ? {sr, sq} : {ur, uq};
`ifdef MDU_MADD_EN
    res     = (op_q == 4'd3 || op_q == 4'd4) ? div_res :
              (op_q == 4'd7 || op_q == 4'd8) ? {hi, lo} + prod :
              (op_q == 4'd9 || op_q == 4'd10) ? {hi, lo} - prod : prod;
`else
    res     = (op_q == 4'd3 || op_q == 4'd4) ? div_res : prod;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      start_err <= 1'b0;
    end else if (state == IDLE) begin
      if (ex_start && is_long) begin
        op_q  <= ex_op;
        a_q   <= ex_a;
        b_q   <= ex_b;
        cnt   <= is_div ? DIV_N : MUL_N;
        state <= BUSY;
      end else if (ex_start && ex_op == 4'd5) begin
        hi <= ex_a;
      end else if (ex_start && ex_op == 4'd6) begin
        lo <= ex_a;
      end
    end else begin
      if (ex_start) start_err <= 1'b1;
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        {hi, lo} <= res;
        state    <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed scoreboard bench for md_sched; commits are checked as busy falls.
module tb_md_sched;
  logic        clk = 0, reset = 0, ex_start = 0, id_md_use = 0;
  logic [3:0]  ex_op = 0;
  logic [31:0] ex_a = 0, ex_b = 0;
  logic        stall_req, busy, start_err;
  logic [31:0] hi, lo;
  int          checks = 0, errors = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_v;
  bit          prev_busy = 0;

  md_sched dut (
    .clk(clk), .reset(reset), .ex_start(ex_start), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .id_md_use(id_md_use), .stall_req(stall_req), .busy(busy), .hi(hi), .lo(lo),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) prev_busy = 0;
    else begin
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_unexpected: got %0h expected no commit", {hi, lo});
        end else begin
          exp_v = sb.pop_front();
          chk("commit", {hi, lo}, exp_v);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input int n, input logic use_id);
    int c;
    @(posedge clk); #1;
    ex_start = 1; ex_op = op; ex_a = a; ex_b = b; id_md_use = use_id;
    sb.push_back(expv);
    @(negedge clk);
    chk("stall_start", stall_req, use_id);
    @(posedge clk); #1;
    ex_start = 0; ex_op = 0; ex_a = 32'hDEADBEEF; ex_b = 32'h0BADF00D;
    c = 0;
    do begin
      @(negedge clk);
      if (busy) begin
        c++;
        if (use_id) chk("stall_busy", stall_req, 1);
      end
    end while (busy && c < 40);
    chk("busy_cycles", c, n);
    chk("stall_after", stall_req, 0);
    id_md_use = 0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    ex_start = 1; ex_op = op; ex_a = a;
    @(posedge clk); #1;
    ex_start = 0; ex_op = 0; ex_a = 32'hDEADBEEF;
    @(negedge clk);
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_err", start_err, 0);
    chk("rst_stall", stall_req, 0);

    run_op(4'd1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 5, 0);
    mt(4'd0, 32'h5555_5555);
    chk("op0_busy", busy, 0);
    chk("op0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(4'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 0);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 0);
    run_op(4'd3, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 10, 0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10, 0);
    run_op(4'd4, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 10, 0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 0);
    run_op(4'd1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5, 1);

    // second start mid-operation must be ignored but flagged
    @(posedge clk); #1;
    ex_start = 1; ex_op = 4'd4; ex_a = 32'd50; ex_b = 32'd5;
    sb.push_back({32'd0, 32'd10});
    @(posedge clk); #1 ex_start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ex_start = 1; ex_op = 4'd1; ex_a = 32'd9; ex_b = 32'd9;
    @(posedge clk); #1 ex_start = 0;
    @(negedge clk);
    chk("err_set", start_err, 1);
    chk("err_busy", busy, 1);
    c = 0;
    while (busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("err_done", busy, 0);
    chk("err_sticky", start_err, 1);

    // async reset in the middle of a divide
    @(posedge clk); #1;
    ex_start = 1; ex_op = 4'd3; ex_a = 32'd1000; ex_b = 32'd3;
    @(posedge clk); #1 ex_start = 0;
    repeat (5) @(posedge clk);
    #2 reset = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hilo", {hi, lo}, 0);
    chk("arst_err", start_err, 0);
    chk("arst_stall", stall_req, 0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1;

    mt(4'd5, 32'd0);
    chk("mthi", hi, 0);
    mt(4'd6, 32'd10);
    chk("mtlo", lo, 10);
    chk("mt_busy", busy, 0);
`ifdef MDU_MADD_EN
    run_op(4'd7, 32'd3, 32'd4, {32'd0, 32'd22}, 5, 0);
    run_op(4'd9, 32'd2, 32'd3, {32'd0, 32'd16}, 5, 1);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd2, 64'h0000_0002_0000_000E, 5, 0);
`else
    @(posedge clk); #1;
    ex_start = 1; ex_op = 4'd7; ex_a = 32'd3; ex_b = 32'd4; id_md_use = 1;
    @(negedge clk);
    chk("madd_off_stall", stall_req, 0);
    @(posedge clk); #1;
    ex_start = 0; ex_op = 0; id_md_use = 0;
    @(negedge clk);
    chk("madd_off_busy", busy, 0);
    chk("madd_off_hilo", {hi, lo}, {32'd0, 32'd10});
`endif
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
